// File: rtl/ball_physics_sched.sv
// ---------------------------------------------------------------------------
// ball_physics_sched
//
// Per-frame physics scheduler for NUM_OBJ bouncing balls. Each frame_end
// pulse starts one pass over the objects in order. Every object goes through
// a single shared datapath in three steps:
//   XUPD   : edge detection and a horizontal step of pxm by SPEED_X
//   YUPD   : ground bounce test and a vertical position/velocity update
//   COMMIT : glow update and write-back of all fields
// A DONE cycle then closes the pass. One pass takes 3*NUM_OBJ+1 cycles.
//
// Optional build macro:
//   BALL_SCHED_DOUBLE_BUF_EN - rd_* reads a display bank. The display bank is
//                              copied from the working bank in the DONE cycle,
//                              so the renderer sees a stable frame.
//   (undefined)              - rd_* reads the working bank live.
//
// Ports:
//   clk         in   pixel clock
//   reset       in   synchronous, active-high reset
//   frame_end   in   single-cycle pulse at the last pixel of a frame
//   rd_idx      in   object select for the read port
//   rd_px       out  px (pxm[11:2]) of the selected object
//   rd_py       out  height above ground of the selected object
//   rd_glow     out  glow threshold of the selected object
//   busy        out  high while an update pass runs
//   done        out  one-cycle pulse once all objects are updated
//   bounce_evt  out  per-object pulse, high in that object's COMMIT cycle
//   overrun     out  pulse when frame_end arrives while busy
// ---------------------------------------------------------------------------
module ball_physics_sched #(
  parameter int NUM_OBJ    = 4,
  parameter int RANGE_X    = 608,
  parameter int SPEED_X    = 9,
  parameter int INIT_VEL   = 21,
  parameter int MIN_VEL    = 17,
  parameter int GLOW_PULSE = 200,
  parameter int GLOW_DECAY = 10,
  parameter int GLOW_MIN   = 15,
  parameter int GLOW_RESET = 10,
  localparam int IDX_W     = $clog2(NUM_OBJ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_end,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [9:0]         rd_px,
  output logic [9:0]         rd_py,
  output logic [7:0]         rd_glow,
  output logic               busy,
  output logic               done,
  output logic [NUM_OBJ-1:0] bounce_evt,
  output logic               overrun
);

  localparam logic [9:0]       RX       = 10'(RANGE_X);
  localparam logic [11:0]      SPD      = 12'(SPEED_X);
  localparam logic [7:0]       VINIT    = 8'(INIT_VEL);
  localparam logic [7:0]       VMIN     = 8'(MIN_VEL);
  localparam logic [7:0]       GPULSE   = 8'(GLOW_PULSE);
  localparam logic [7:0]       GDEC     = 8'(GLOW_DECAY);
  localparam logic [7:0]       GMIN     = 8'(GLOW_MIN);
  localparam logic [7:0]       GRST     = 8'(GLOW_RESET);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XUPD,
    S_YUPD,
    S_COMMIT,
    S_DONE
  } state_t;

  // Objects start evenly spread across the playfield.
  function automatic logic [11:0] pxm_init(input int i);
    pxm_init = 12'(i * (RANGE_X / NUM_OBJ) * 4);
  endfunction

  // A hit re-arms the glow; otherwise it fades down to a floor.
  function automatic logic [7:0] glow_next(input logic [7:0] g, input logic hit);
    if (hit) begin
      glow_next = GPULSE;
    end else if (g > GMIN) begin
      glow_next = g - GDEC;
    end else begin
      glow_next = g;
    end
  endfunction

  // Control
  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic [NUM_OBJ-1:0] bounce_evt_q;

  // Working bank (committed object state)
  logic [11:0]        pxm_q  [NUM_OBJ];
  logic [9:0]         py_q   [NUM_OBJ];
  logic signed [7:0]  vel_q  [NUM_OBJ];
  logic [NUM_OBJ-1:0] dx_q;
  logic [7:0]         glow_q [NUM_OBJ];

  // Per-object scratch carried from XUPD/YUPD into COMMIT
  logic [11:0]        xs_pxm_q;
  logic               xs_dx_q;
  logic               xs_edge_q;
  logic [9:0]         ys_py_q;
  logic signed [7:0]  ys_vel_q;
  logic               ys_bnc_q;

  // Shared datapath
  logic [11:0]        cur_pxm;
  logic [9:0]         cur_px;
  logic [9:0]         cur_py;
  logic signed [7:0]  cur_vel;
  logic [7:0]         cur_glow;
  logic               edge_d;
  logic               dx_d;
  logic [11:0]        pxm_d;
  logic signed [11:0] py_ext;
  logic signed [11:0] nvel_ext;
  logic               bnc_d;
  logic [9:0]         py_d;
  logic signed [7:0]  vel_d;
  logic [7:0]         glow_d;

  always_comb begin
    cur_pxm  = pxm_q[idx_q];
    cur_px   = cur_pxm[11:2];
    cur_py   = py_q[idx_q];
    cur_vel  = vel_q[idx_q];
    cur_glow = glow_q[idx_q];

    // Horizontal: the wall test uses the stored px, then the step follows
    // the (possibly flipped) direction. pxm wraps mod 2^12.
    edge_d = (cur_px >= RX) || (cur_px == 10'd0);
    if (cur_px >= RX) begin
      dx_d = 1'b0;
    end else if (cur_px == 10'd0) begin
      dx_d = 1'b1;
    end else begin
      dx_d = dx_q[idx_q];
    end
    pxm_d = dx_d ? (cur_pxm + SPD) : (cur_pxm - SPD);

    // Vertical: bounce when falling and the next step would reach ground.
    // Compared in 12-bit signed so that -(-128) does not overflow.
    py_ext   = signed'({2'b00, cur_py});
    nvel_ext = -(12'(cur_vel));
    bnc_d    = cur_vel[7] && (py_ext <= nvel_ext);
    if (bnc_d) begin
      // pxm_q is not written until COMMIT, so cur_px is still the pre-step px.
      py_d  = '0;
      vel_d = signed'(VMIN + {5'b00000, cur_px[2:0]});
    end else begin
      py_d  = cur_py + 10'(cur_vel);
      vel_d = cur_vel - 8'sd1;
    end

    glow_d = glow_next(cur_glow, ys_bnc_q | xs_edge_q);
  end

  // XUPD / YUPD -> COMMIT scratch registers
  always_ff @(posedge clk) begin
    if (state_q == S_XUPD) begin
      xs_pxm_q  <= pxm_d;
      xs_dx_q   <= dx_d;
      xs_edge_q <= edge_d;
    end
    if (state_q == S_YUPD) begin
      ys_py_q  <= py_d;
      ys_vel_q <= vel_d;
      ys_bnc_q <= bnc_d;
    end
  end

  // Sequencer and working-bank write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bounce_evt_q <= '0;
      dx_q         <= '1;
      for (int i = 0; i < NUM_OBJ; i++) begin
        pxm_q[i]  <= pxm_init(i);
        py_q[i]   <= '0;
        vel_q[i]  <= signed'(VINIT);
        glow_q[i] <= GRST;
      end
    end else begin
      done_q       <= 1'b0;
      bounce_evt_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_end) begin
            state_q <= S_XUPD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_XUPD: begin
          state_q <= S_YUPD;
        end
        S_YUPD: begin
          // Registered so the pulse lines up with this object's COMMIT cycle.
          bounce_evt_q[idx_q] <= bnc_d;
          state_q             <= S_COMMIT;
        end
        S_COMMIT: begin
          pxm_q[idx_q]  <= xs_pxm_q;
          dx_q[idx_q]   <= xs_dx_q;
          py_q[idx_q]   <= ys_py_q;
          vel_q[idx_q]  <= ys_vel_q;
          glow_q[idx_q] <= glow_d;
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_XUPD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bounce_evt = bounce_evt_q;
  // frame_end during a pass is dropped; flag it in the same cycle.
  assign overrun    = frame_end & busy_q;

`ifdef BALL_SCHED_DOUBLE_BUF_EN
  // Display bank: refreshed once per pass so the renderer never sees a
  // half-updated frame.
  logic [9:0] disp_px_q   [NUM_OBJ];
  logic [9:0] disp_py_q   [NUM_OBJ];
  logic [7:0] disp_glow_q [NUM_OBJ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        disp_px_q[i]   <= pxm_init(i) >> 2;
        disp_py_q[i]   <= '0;
        disp_glow_q[i] <= GRST;
      end
    end else if (state_q == S_DONE) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        disp_px_q[i]   <= pxm_q[i][11:2];
        disp_py_q[i]   <= py_q[i];
        disp_glow_q[i] <= glow_q[i];
      end
    end
  end

  assign rd_px   = disp_px_q[rd_idx];
  assign rd_py   = disp_py_q[rd_idx];
  assign rd_glow = disp_glow_q[rd_idx];
`else
  logic [11:0] rd_pxm;
  assign rd_pxm  = pxm_q[rd_idx];
  assign rd_px   = rd_pxm[11:2];
  assign rd_py   = py_q[rd_idx];
  assign rd_glow = glow_q[rd_idx];
`endif

endmodule

// File: tb/tb_ball_physics_sched.sv
// Self-checking bench for ball_physics_sched. A frame-level reference model
// (plain integer arithmetic) predicts object state and bounce events.
// Randomized frame gaps, overrun positions and read indices.
module tb_ball_physics_sched;

  localparam int NUM_OBJ    = 4;
  localparam int RANGE_X    = 608;
  localparam int SPEED_X    = 9;
  localparam int INIT_VEL   = 21;
  localparam int MIN_VEL    = 17;
  localparam int GLOW_PULSE = 200;
  localparam int GLOW_DECAY = 10;
  localparam int GLOW_MIN   = 15;
  localparam int GLOW_RESET = 10;
  localparam int IDX_W      = $clog2(NUM_OBJ);
  localparam int FRAME_CYC  = 3 * NUM_OBJ + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_end = 1'b0;
  logic [IDX_W-1:0]   rd_idx = '0;
  logic [9:0]         rd_px;
  logic [9:0]         rd_py;
  logic [7:0]         rd_glow;
  logic               busy;
  logic               done;
  logic [NUM_OBJ-1:0] bounce_evt;
  logic               overrun;

  ball_physics_sched #(
    .NUM_OBJ(NUM_OBJ), .RANGE_X(RANGE_X), .SPEED_X(SPEED_X),
    .INIT_VEL(INIT_VEL), .MIN_VEL(MIN_VEL), .GLOW_PULSE(GLOW_PULSE),
    .GLOW_DECAY(GLOW_DECAY), .GLOW_MIN(GLOW_MIN), .GLOW_RESET(GLOW_RESET)
  ) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end), .rd_idx(rd_idx),
    .rd_px(rd_px), .rd_py(rd_py), .rd_glow(rd_glow), .busy(busy),
    .done(done), .bounce_evt(bounce_evt), .overrun(overrun)
  );

  always #10 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: one call = one whole frame of physics.
  int                 m_pxm [NUM_OBJ];
  int                 m_py  [NUM_OBJ];
  int                 m_vel [NUM_OBJ];
  int                 m_dx  [NUM_OBJ];
  int                 m_glow[NUM_OBJ];
  logic [NUM_OBJ-1:0] m_bnc;

  function automatic void model_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      m_pxm[i]  = i * (RANGE_X / NUM_OBJ) * 4;
      m_py[i]   = 0;
      m_vel[i]  = INIT_VEL;
      m_dx[i]   = 1;
      m_glow[i] = GLOW_RESET;
    end
    m_bnc = '0;
  endfunction

  function automatic void model_frame();
    int px;
    bit hit;
    bit b;
    m_bnc = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      px  = m_pxm[i] / 4;
      hit = (px >= RANGE_X) || (px == 0);
      if (px >= RANGE_X) m_dx[i] = 0;
      else if (px == 0) m_dx[i] = 1;
      m_pxm[i] = (m_pxm[i] + ((m_dx[i] == 1) ? SPEED_X : 4096 - SPEED_X)) % 4096;
      b = (m_vel[i] < 0) && (m_py[i] <= -m_vel[i]);
      if (b) begin
        m_py[i]  = 0;
        m_vel[i] = MIN_VEL + (px % 8);
      end else begin
        m_py[i]  = (m_py[i] + m_vel[i] + 1024) % 1024;
        m_vel[i] = m_vel[i] - 1;
        if (m_vel[i] < -128) m_vel[i] += 256;
      end
      if (b || hit) m_glow[i] = GLOW_PULSE;
      else if (m_glow[i] > GLOW_MIN) m_glow[i] = m_glow[i] - GLOW_DECAY;
      m_bnc[i] = b;
    end
  endfunction

  // Observations recorded by do_frame / snap
  int                 busy_cnt, done_cnt, done_cyc, ovr_cnt, ovr_at, bev_stray, last_k;
  bit                 tmo;
  logic [NUM_OBJ-1:0] bev_log;
  int                 trace [64];
  int                 o_px [NUM_OBJ];
  int                 o_py [NUM_OBJ];
  int                 o_gl [NUM_OBJ];

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_end = 1'b0;
    rd_idx = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Reads every object through the read port (no clock edge in between).
  task automatic snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      o_px[i] = int'(rd_px);
      o_py[i] = int'(rd_py);
      o_gl[i] = int'(rd_glow);
    end
  endtask

  // Launches one frame, optionally re-pulsing frame_end on busy cycle ovr_cyc,
  // and records what the DUT does cycle by cycle until busy drops.
  task automatic do_frame(input int ovr_cyc);
    int k;
    bit fin;
    logic [NUM_OBJ-1:0] allowed;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; ovr_cnt = 0; ovr_at = 0;
    bev_stray = 0; bev_log = '0; tmo = 0;
    for (int i = 0; i < 64; i++) trace[i] = -1;
    rd_idx = '0;
    @(negedge clk);
    frame_end = 1'b1;
    #1;
    if (overrun) ovr_cnt++;
    @(negedge clk);
    frame_end = 1'b0;
    k = 1;
    fin = 0;
    while (!fin) begin
      if (k == ovr_cyc) frame_end = 1'b1;
      #1;
      trace[k] = int'(rd_px);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = k; end
      if (overrun) begin ovr_cnt++; ovr_at = k; end
      allowed = '0;
      if ((k % 3 == 0) && (k >= 3) && (k <= 3 * NUM_OBJ)) allowed[k / 3 - 1] = 1'b1;
      if ((bounce_evt & ~allowed) != '0) bev_stray++;
      bev_log = bev_log | bounce_evt;
      if (!busy) fin = 1;
      else if (k >= 40) begin tmo = 1; fin = 1; end
      else begin
        @(negedge clk);
        frame_end = 1'b0;
        k++;
      end
    end
    frame_end = 1'b0;
    last_k = k;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || bounce_evt !== '0)
      $display("FAIL reset_ctrl: busy=%0b done=%0b overrun=%0b bev=%b, want all 0",
               busy, done, overrun, bounce_evt);
    else n_pass++;
    snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      n_total++;
      if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
        $display("FAIL reset_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                 i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
      else n_pass++;
    end
    n_total++;
    if (o_px[0] != 0 || o_py[0] != 0 || o_gl[0] != 10 || o_px[1] != 152)
      $display("FAIL reset_const: obj0 %0d/%0d/%0d obj1 px %0d, want 0/0/10 and 152",
               o_px[0], o_py[0], o_gl[0], o_px[1]);
    else n_pass++;
  endtask

  task automatic test_one_frame();
    int old_px0;
    int new_px0;
    int want;
    apply_reset();
    old_px0 = m_pxm[0] / 4;
    do_frame(0);
    model_frame();
    new_px0 = m_pxm[0] / 4;
    n_total++;
    if (tmo || busy_cnt != FRAME_CYC)
      $display("FAIL frame_busy: busy cycles %0d (timeout %0b), want %0d", busy_cnt, tmo, FRAME_CYC);
    else n_pass++;
    n_total++;
    if (done_cnt != 1 || done_cyc != FRAME_CYC)
      $display("FAIL frame_done: %0d pulses at cycle %0d, want 1 at %0d", done_cnt, done_cyc, FRAME_CYC);
    else n_pass++;
    n_total++;
    if (ovr_cnt != 0 || bev_stray != 0 || bev_log !== m_bnc)
      $display("FAIL frame_evt: overrun %0d stray %0d bev %b, want 0 0 %b", ovr_cnt, bev_stray, bev_log, m_bnc);
    else n_pass++;
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
`ifdef BALL_SCHED_DOUBLE_BUF_EN
      want = (k <= FRAME_CYC) ? old_px0 : new_px0;
`else
      want = (k <= 3) ? old_px0 : new_px0;
`endif
      n_total++;
      if (trace[k] != want)
        $display("FAIL rdpx0_cycle%0d: got %0d want %0d", k, trace[k], want);
      else n_pass++;
    end
    snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      n_total++;
      if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
        $display("FAIL frame1_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                 i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
      else n_pass++;
    end
    n_total++;
    if (o_px[0] != 2 || o_py[0] != 21 || o_gl[0] != 200 ||
        o_px[1] != 154 || o_py[1] != 21 || o_gl[1] != 10)
      $display("FAIL frame1_const: obj0 %0d/%0d/%0d obj1 %0d/%0d/%0d, want 2/21/200 154/21/10",
               o_px[0], o_py[0], o_gl[0], o_px[1], o_py[1], o_gl[1]);
    else n_pass++;
  endtask

  task automatic test_long_run();
    int px43;
    px43 = 0;
    apply_reset();
    for (int f = 1; f <= 70; f++) begin
      if (f == 43) px43 = m_pxm[0] / 4;
      do_frame(0);
      model_frame();
      n_total++;
      if (tmo || done_cnt != 1 || done_cyc != FRAME_CYC || bev_stray != 0 || bev_log !== m_bnc)
        $display("FAIL run_f%0d_ctrl: done %0d@%0d stray %0d bev %b, want 1@%0d 0 %b",
                 f, done_cnt, done_cyc, bev_stray, bev_log, FRAME_CYC, m_bnc);
      else n_pass++;
      snap();
      for (int i = 0; i < NUM_OBJ; i++) begin
        n_total++;
        if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
          $display("FAIL run_f%0d_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                   f, i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
        else n_pass++;
      end
      if (f == 43) begin
        n_total++;
        if (bev_log[0] !== 1'b1 || o_py[0] != 0 || o_gl[0] != 200)
          $display("FAIL bounce_f43: bev0=%0b py=%0d glow=%0d, want 1 0 200", bev_log[0], o_py[0], o_gl[0]);
        else n_pass++;
      end
      if (f == 44) begin
        n_total++;
        if (o_py[0] != MIN_VEL + (px43 % 8))
          $display("FAIL bounce_vel: py after f44 %0d want %0d", o_py[0], MIN_VEL + (px43 % 8));
        else n_pass++;
      end
      if (f == 68) begin
        n_total++;
        if (o_px[3] != 609)
          $display("FAIL edge_f68: obj3 px %0d want 609", o_px[3]);
        else n_pass++;
      end
      if (f == 69) begin
        n_total++;
        if (o_px[3] != 606 || o_gl[3] != 200)
          $display("FAIL edge_f69: obj3 px %0d glow %0d, want 606 200", o_px[3], o_gl[3]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    do_frame(5);
    model_frame();
    n_total++;
    if (ovr_cnt != 1 || ovr_at != 5)
      $display("FAIL overrun_pulse: %0d pulses, last at %0d, want 1 at 5", ovr_cnt, ovr_at);
    else n_pass++;
    n_total++;
    if (tmo || done_cnt != 1 || busy_cnt != FRAME_CYC)
      $display("FAIL overrun_seq: done %0d busy %0d, want 1 %0d", done_cnt, busy_cnt, FRAME_CYC);
    else n_pass++;
    // The ignored frame_end must not start a second pass.
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL overrun_restart: busy=%0b want 0", busy);
    else n_pass++;
    snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      n_total++;
      if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
        $display("FAIL overrun_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                 i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_frame(0);
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL midrst_busy_before: busy=%0b want 1", busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || bounce_evt !== '0)
      $display("FAIL midrst_ctrl: busy=%0b done=%0b bev=%b, want 0 0 0", busy, done, bounce_evt);
    else n_pass++;
    snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      n_total++;
      if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
        $display("FAIL midrst_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                 i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
      else n_pass++;
    end
    // A fresh pass after the abort must start again from object 0.
    do_frame(0);
    model_frame();
    snap();
    for (int i = 0; i < NUM_OBJ; i++) begin
      n_total++;
      if (o_px[i] != m_pxm[i] / 4 || o_py[i] != m_py[i] || o_gl[i] != m_glow[i])
        $display("FAIL midrst_next_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                 i, o_px[i], o_py[i], o_gl[i], m_pxm[i] / 4, m_py[i], m_glow[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int gap;
    int oc;
    int j;
    apply_reset();
    for (int f = 0; f < 40; f++) begin
      gap = $urandom_range(0, 4);
      oc  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, FRAME_CYC) : 0;
      repeat (gap) @(negedge clk);
      do_frame(oc);
      model_frame();
      n_total++;
      if (tmo || busy_cnt != FRAME_CYC || done_cnt != 1 || ovr_cnt != ((oc != 0) ? 1 : 0))
        $display("FAIL rnd_f%0d_ctrl: busy %0d done %0d ovr %0d (oc %0d)", f, busy_cnt, done_cnt, ovr_cnt, oc);
      else n_pass++;
      n_total++;
      if (bev_stray != 0 || bev_log !== m_bnc)
        $display("FAIL rnd_f%0d_bev: stray %0d bev %b want %b", f, bev_stray, bev_log, m_bnc);
      else n_pass++;
      for (int r = 0; r < 3; r++) begin
        j = $urandom_range(0, NUM_OBJ - 1);
        rd_idx = IDX_W'(j);
        #1;
        n_total++;
        if (int'(rd_px) != m_pxm[j] / 4 || int'(rd_py) != m_py[j] || int'(rd_glow) != m_glow[j])
          $display("FAIL rnd_f%0d_obj%0d: px/py/glow=%0d/%0d/%0d want %0d/%0d/%0d",
                   f, j, rd_px, rd_py, rd_glow, m_pxm[j] / 4, m_py[j], m_glow[j]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_frame();
    test_long_run();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
